// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus datapath: ALU op codes, branch
// condition codes and the instruction-register field positions.
package data_path_pkg;

   typedef enum logic [4:0] {
      OP_NONE = 5'd0,
      OP_AND  = 5'd1,
      OP_OR   = 5'd2,
      OP_ADD  = 5'd3,
      OP_SUB  = 5'd4,
      OP_SHR  = 5'd5,
      OP_SHRA = 5'd6,
      OP_SHL  = 5'd7,
      OP_ROR  = 5'd8,
      OP_ROL  = 5'd9,
      OP_MUL  = 5'd10,
      OP_DIV  = 5'd11,
      OP_NEG  = 5'd12,
      OP_NOT  = 5'd13
   } aluOp_e;

   typedef enum logic [1:0] {
      C2_ZERO    = 2'b00,
      C2_NONZERO = 2'b01,
      C2_POS     = 2'b10,
      C2_NEG     = 2'b11
   } cond_e;

   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_LSB = 15;
   localparam int IR_C2_LSB = 19;
   localparam int IR_C_MSB  = 18;

   function automatic logic [31:0] immC(input logic [31:0] ir);
      return {{(31 - IR_C_MSB){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};
   endfunction

endpackage

// File: rtl/data_path_if.sv
// Control strobes, memory and port signals of the datapath. Bit i of RegOut /
// RegIn is the Riout / Riin strobe of general register Ri.
interface data_path_if;
   logic [31:0] Mdatain;
   logic [31:0] InPortData;
   logic [15:0] RegOut;
   logic [15:0] RegIn;
   logic        RAout, HIout, LOout, RZHIout, RZLOout, PCout, IRout, RYout;
   logic        MDRout, MARout, PORTout, cout;
   logic        RAin, HIin, LOin, RYin, RZin, PCin, IRin, MDRin, MARin, PORTin;
   logic        gra, grb, grc, rin, rout, BAout;
   logic        Read, Write, IncPC, conin;
   logic [4:0]  ops;
   logic [31:0] OutPortData;
   logic [31:0] MemAddr;
   logic [31:0] MemDataOut;
   logic        CON;

   modport master (
      output Mdatain, InPortData, RegOut, RegIn,
      output RAout, HIout, LOout, RZHIout, RZLOout, PCout, IRout, RYout,
      output MDRout, MARout, PORTout, cout,
      output RAin, HIin, LOin, RYin, RZin, PCin, IRin, MDRin, MARin, PORTin,
      output gra, grb, grc, rin, rout, BAout,
      output Read, Write, IncPC, conin, ops,
      input  OutPortData, MemAddr, MemDataOut, CON
   );

   modport slave (
      input  Mdatain, InPortData, RegOut, RegIn,
      input  RAout, HIout, LOout, RZHIout, RZLOout, PCout, IRout, RYout,
      input  MDRout, MARout, PORTout, cout,
      input  RAin, HIin, LOin, RYin, RZin, PCin, IRin, MDRin, MARin, PORTin,
      input  gra, grb, grc, rin, rout, BAout,
      input  Read, IncPC, conin, ops,
      output OutPortData, MemAddr, MemDataOut, CON
   );

   // External memory only needs the address/data registers and the strobes.
   modport memory (
      input  Read, Write, MemAddr, MemDataOut,
      output Mdatain
   );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus; produces the 64-bit value
// that Z loads. IncPC forces bus+1 regardless of the op code.
module alu
   import data_path_pkg::*;
(
   input  logic [4:0]  ops_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        incPc_i,
   output logic [63:0] result_o
);

   logic [4:0]         shamt;
   logic signed [63:0] product;
   logic signed [31:0] quotient;
   logic signed [31:0] remainder;
   logic [63:0]        rorWide;
   logic [63:0]        rolWide;

   always_comb begin
      shamt     = b_i[4:0];
      product   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
      quotient  = '0;
      remainder = '0;
      // Division by zero leaves both halves at zero instead of trapping.
      if (b_i != 32'd0) begin
         quotient  = $signed(a_i) / $signed(b_i);
         remainder = $signed(a_i) % $signed(b_i);
      end
      rorWide = {a_i, a_i} >> shamt;
      rolWide = {a_i, a_i} << shamt;

      result_o = '0;
      if (incPc_i) begin
         result_o = {32'd0, b_i + 32'd1};
      end else begin
         case (ops_i)
            OP_AND:  result_o = {32'd0, a_i & b_i};
            OP_OR:   result_o = {32'd0, a_i | b_i};
            OP_ADD:  result_o = {32'd0, a_i + b_i};
            OP_SUB:  result_o = {32'd0, a_i - b_i};
            OP_SHR:  result_o = {32'd0, a_i >> shamt};
            OP_SHRA: result_o = {32'd0, 32'($signed(a_i) >>> shamt)};
            OP_SHL:  result_o = {32'd0, a_i << shamt};
            OP_ROR:  result_o = {32'd0, rorWide[31:0]};
            OP_ROL:  result_o = {32'd0, rolWide[63:32]};
            OP_MUL:  result_o = product;
            OP_DIV:  result_o = {remainder, quotient};
            OP_NEG:  result_o = {32'd0, 32'd0 - b_i};
            OP_NOT:  result_o = {32'd0, ~b_i};
            default: result_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU and
// branch condition logic joined by one combinational priority bus.
module data_path
   import data_path_pkg::*;
(
   input logic        clock,
   input logic        clear,
   data_path_if.slave dp
);

   logic [31:0] rf_q [16];
   logic [31:0] ra_q, hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q, port_q;
   logic [63:0] z_q;
   logic        con_q;

   logic [31:0] mdr_d;
   logic [63:0] z_d;
   logic        con_d;

   logic [3:0]  idx;
   logic [15:0] sel;
   logic [15:0] regLoad;
   logic [15:0] regDrive;
   logic        baZero;
   logic [31:0] busValue;

   // Select-and-encode: the IR register fields pick which Ri an rin/rout acts on.
   always_comb begin
      idx = (dp.gra ? ir_q[IR_RA_LSB +: 4] : 4'd0)
          | (dp.grb ? ir_q[IR_RB_LSB +: 4] : 4'd0)
          | (dp.grc ? ir_q[IR_RC_LSB +: 4] : 4'd0);
      sel      = 16'd1 << idx;
      regLoad  = dp.RegIn | ({16{dp.rin}} & sel);
      regDrive = dp.RegOut | ({16{dp.rout | dp.BAout}} & sel);
      baZero   = dp.BAout & sel[0];
   end

   // Lowest-priority source is assigned first so higher ones overwrite it.
   always_comb begin
      busValue = '0;
      if (dp.IRout)   busValue = ir_q;
      if (dp.MARout)  busValue = mar_q;
      if (dp.RYout)   busValue = y_q;
      if (dp.cout)    busValue = immC(ir_q);
      if (dp.PORTout) busValue = dp.InPortData;
      if (dp.MDRout)  busValue = mdr_q;
      if (dp.PCout)   busValue = pc_q;
      if (dp.RZLOout) busValue = z_q[31:0];
      if (dp.RZHIout) busValue = z_q[63:32];
      if (dp.LOout)   busValue = lo_q;
      if (dp.HIout)   busValue = hi_q;
      if (dp.RAout)   busValue = ra_q;
      for (int i = 15; i >= 0; i--) begin
         if (regDrive[i]) busValue = rf_q[i];
      end
      if (regDrive[0] && baZero) busValue = '0;
   end

   alu uAlu (
      .ops_i    (dp.ops),
      .a_i      (y_q),
      .b_i      (busValue),
      .incPc_i  (dp.IncPC),
      .result_o (z_d)
   );

   always_comb begin
      mdr_d = dp.Read ? dp.Mdatain : busValue;
      con_d = 1'b0;
      case (ir_q[IR_C2_LSB +: 2])
         C2_ZERO:    con_d = (busValue == 32'd0);
         C2_NONZERO: con_d = (busValue != 32'd0);
         C2_POS:     con_d = !busValue[31] && (busValue != 32'd0);
         C2_NEG:     con_d = busValue[31];
         default:    con_d = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (regLoad[i]) rf_q[i] <= busValue;
         end
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ra_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         y_q    <= '0;
         pc_q   <= '0;
         ir_q   <= '0;
         mar_q  <= '0;
         mdr_q  <= '0;
         port_q <= '0;
         z_q    <= '0;
         con_q  <= 1'b0;
      end else begin
         if (dp.RAin)   ra_q   <= busValue;
         if (dp.HIin)   hi_q   <= busValue;
         if (dp.LOin)   lo_q   <= busValue;
         if (dp.RYin)   y_q    <= busValue;
         if (dp.PCin)   pc_q   <= busValue;
         if (dp.IRin)   ir_q   <= busValue;
         if (dp.MARin)  mar_q  <= busValue;
         if (dp.MDRin)  mdr_q  <= mdr_d;
         if (dp.PORTin) port_q <= busValue;
         if (dp.RZin)   z_q    <= z_d;
         if (dp.conin)  con_q  <= con_d;
      end
   end

   assign dp.OutPortData = port_q;
   assign dp.MemAddr     = mar_q;
   assign dp.MemDataOut  = mdr_q;
   assign dp.CON         = con_q;

endmodule

// File: tb/tb_data_path.sv
// Testbench for data_path: drives control-unit microsteps and checks results
// through the externally visible registers with an expectation queue.
module tb_data_path;
   import data_path_pkg::*;

   logic clock = 1'b0;
   logic clear = 1'b0;

   data_path_if dpIf ();

   data_path dut (
      .clock (clock),
      .clear (clear),
      .dp    (dpIf)
   );

   always #5 clock = ~clock;

   localparam int SINK_MAR  = 0;
   localparam int SINK_MDR  = 1;
   localparam int SINK_PORT = 2;
   localparam int SINK_CON  = 3;
   localparam int SRC_ZLO   = 16;
   localparam int SRC_ZHI   = 17;
   localparam int SRC_PC    = 18;
   localparam int SRC_IR    = 19;

   typedef struct {
      string       tag;
      int          sink;
      logic [31:0] value;
   } expect_t;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] b;
      logic [31:0] lo;
   } aluVec_t;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } wideVec_t;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] bus;
      logic        con;
   } conVec_t;

   expect_t sb[$];
   int vectorsApplied = 0;
   int miscompares    = 0;

   function automatic logic [31:0] sinkValue(input int sink);
      case (sink)
         SINK_MAR:  return dpIf.MemAddr;
         SINK_MDR:  return dpIf.MemDataOut;
         SINK_PORT: return dpIf.OutPortData;
         default:   return {31'd0, dpIf.CON};
      endcase
   endfunction

   task automatic idle();
      dpIf.RegOut = '0;   dpIf.RegIn = '0;
      dpIf.RAout = 0; dpIf.HIout = 0; dpIf.LOout = 0; dpIf.RZHIout = 0;
      dpIf.RZLOout = 0; dpIf.PCout = 0; dpIf.IRout = 0; dpIf.RYout = 0;
      dpIf.MDRout = 0; dpIf.MARout = 0; dpIf.PORTout = 0; dpIf.cout = 0;
      dpIf.RAin = 0; dpIf.HIin = 0; dpIf.LOin = 0; dpIf.RYin = 0; dpIf.RZin = 0;
      dpIf.PCin = 0; dpIf.IRin = 0; dpIf.MDRin = 0; dpIf.MARin = 0; dpIf.PORTin = 0;
      dpIf.gra = 0; dpIf.grb = 0; dpIf.grc = 0; dpIf.rin = 0; dpIf.rout = 0;
      dpIf.BAout = 0; dpIf.Read = 0; dpIf.Write = 0; dpIf.IncPC = 0; dpIf.conin = 0;
      dpIf.ops = 5'd0;
   endtask

   // One microstep: strobes set by the caller take effect on the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic loadReg(input int r, input logic [31:0] v);
      dpIf.InPortData = v; dpIf.PORTout = 1; dpIf.RegIn[r] = 1'b1; step();
   endtask

   task automatic loadIr(input logic [31:0] v);
      dpIf.InPortData = v; dpIf.PORTout = 1; dpIf.IRin = 1; step();
   endtask

   task automatic loadPc(input logic [31:0] v);
      dpIf.InPortData = v; dpIf.PORTout = 1; dpIf.PCin = 1; step();
   endtask

   task automatic loadY(input logic [31:0] v);
      dpIf.InPortData = v; dpIf.PORTout = 1; dpIf.RYin = 1; step();
   endtask

   task automatic expectVia(input string tag, input int src, input int sink,
                            input logic [31:0] v);
      sb.push_back('{tag, sink, v});
      if (src < 16) dpIf.RegOut[src] = 1'b1;
      else if (src == SRC_ZLO) dpIf.RZLOout = 1;
      else if (src == SRC_ZHI) dpIf.RZHIout = 1;
      else if (src == SRC_PC)  dpIf.PCout = 1;
      else                     dpIf.IRout = 1;
      if (sink == SINK_MAR)      dpIf.MARin = 1;
      else if (sink == SINK_MDR) dpIf.MDRin = 1;
      else                       dpIf.PORTin = 1;
      step();
   endtask

   task automatic test_reset();
      expect_t e;
      logic [31:0] obs;
      #12 clear = 1'b1;
      dpIf.InPortData = 32'h0000_1234;
      dpIf.PORTout = 1; dpIf.MARin = 1; dpIf.MDRin = 1; dpIf.PORTin = 1;
      step();
      dpIf.conin = 1;
      step();
      sb.push_back('{"pre-clear MAR", SINK_MAR, 32'h1234});
      sb.push_back('{"pre-clear MDR", SINK_MDR, 32'h1234});
      sb.push_back('{"pre-clear PORT", SINK_PORT, 32'h1234});
      sb.push_back('{"pre-clear CON", SINK_CON, 32'd1});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
      clear = 1'b0;
      #1;
      for (int s = 0; s < 4; s++) sb.push_back('{$sformatf("reset sink%0d", s), s, 32'd0});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
      #2 clear = 1'b1;
   endtask

   task automatic runBranch(input logic [31:0] r2Val, input logic expCon);
      expect_t e;
      logic [31:0] obs;
      loadReg(2, r2Val);
      loadPc(32'd0);
      dpIf.Mdatain = 32'h9100_0023;
      dpIf.PCout = 1; dpIf.MARin = 1; dpIf.IncPC = 1; dpIf.RZin = 1; step();
      dpIf.RZLOout = 1; dpIf.PCin = 1; dpIf.Read = 1; dpIf.MDRin = 1; step();
      dpIf.MDRout = 1; dpIf.IRin = 1; step();
      dpIf.gra = 1; dpIf.rout = 1; dpIf.conin = 1; step();
      dpIf.PCout = 1; dpIf.RYin = 1; step();
      dpIf.cout = 1; dpIf.ops = OP_ADD; dpIf.RZin = 1; step();
      sb.push_back('{$sformatf("branch CON r2=%0d", r2Val), SINK_CON, {31'd0, expCon}});
      expectVia("branch ZLO", SRC_ZLO, SINK_PORT, 32'h24);
      expectVia("branch ZHI", SRC_ZHI, SINK_MDR, 32'h0);
      expectVia("branch PC", SRC_PC, SINK_MAR, 32'h1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
   endtask

   task automatic test_branch();
      runBranch(32'd0, 1'b1);
      runBranch(32'd5, 1'b0);
   endtask

   task automatic test_add_sub();
      expect_t e;
      logic [31:0] obs;
      loadReg(3, 32'd7);
      loadReg(4, 32'hFFFF_FFFF);
      loadReg(5, 32'd9);
      dpIf.RegOut[3] = 1; dpIf.RYin = 1; step();
      dpIf.RegOut[4] = 1; dpIf.ops = OP_ADD; dpIf.RZin = 1; step();
      expectVia("add ZLO", SRC_ZLO, SINK_PORT, 32'd6);
      expectVia("add ZHI", SRC_ZHI, SINK_MAR, 32'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
      dpIf.RegOut[3] = 1; dpIf.RYin = 1; step();
      dpIf.RegOut[5] = 1; dpIf.ops = OP_SUB; dpIf.RZin = 1; step();
      expectVia("sub ZLO", SRC_ZLO, SINK_PORT, 32'hFFFF_FFFE);
      expectVia("sub ZHI", SRC_ZHI, SINK_MAR, 32'd0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
   endtask

   task automatic test_alu_ops();
      expect_t e;
      logic [31:0] obs;
      aluVec_t vecs [12];
      vecs = '{
         '{OP_AND,  32'h0FF0_00FF, 32'h0000_000F},
         '{OP_OR,   32'h0FF0_00FF, 32'hFFF0_00FF},
         '{OP_SHR,  32'd4,         32'h0F00_0000},
         '{OP_SHRA, 32'd4,         32'hFF00_0000},
         '{OP_SHL,  32'd4,         32'h0000_00F0},
         '{OP_ROR,  32'd4,         32'hFF00_0000},
         '{OP_ROL,  32'd4,         32'h0000_00FF},
         '{OP_ROL,  32'd0,         32'hF000_000F},
         '{OP_ROR,  32'd36,        32'hFF00_0000},
         '{OP_NEG,  32'd1,         32'hFFFF_FFFF},
         '{OP_NOT,  32'h0F0F_0F0F, 32'hF0F0_F0F0},
         '{5'h1F,   32'd5,         32'h0000_0000}
      };
      loadY(32'hF000_000F);
      foreach (vecs[i]) begin
         dpIf.InPortData = vecs[i].b; dpIf.PORTout = 1;
         dpIf.ops = vecs[i].op; dpIf.RZin = 1; step();
         expectVia($sformatf("alu op%0d b=%0h ZLO", vecs[i].op, vecs[i].b),
                   SRC_ZLO, SINK_PORT, vecs[i].lo);
         expectVia($sformatf("alu op%0d ZHI", vecs[i].op), SRC_ZHI, SINK_MAR, 32'd0);
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
            if (obs !== e.value) begin
               miscompares++;
               $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
            end
         end
      end
   endtask

   task automatic test_mul_div();
      expect_t e;
      logic [31:0] obs;
      wideVec_t vecs [5];
      vecs = '{
         '{OP_MUL, 32'hFFFF_FFFD, 32'd4,       32'hFFFF_FFFF, 32'hFFFF_FFF4},
         '{OP_MUL, 32'h0001_0000, 32'h10000,   32'h0000_0001, 32'h0000_0000},
         '{OP_DIV, 32'd17,        32'd5,       32'd2,         32'd3},
         '{OP_DIV, 32'hFFFF_FFEF, 32'd5,       32'hFFFF_FFFE, 32'hFFFF_FFFD},
         '{OP_DIV, 32'd17,        32'd0,       32'd0,         32'd0}
      };
      foreach (vecs[i]) begin
         loadY(vecs[i].a);
         dpIf.InPortData = vecs[i].b; dpIf.PORTout = 1;
         dpIf.ops = vecs[i].op; dpIf.RZin = 1; step();
         expectVia($sformatf("op%0d %0h,%0h ZLO", vecs[i].op, vecs[i].a, vecs[i].b),
                   SRC_ZLO, SINK_PORT, vecs[i].lo);
         expectVia($sformatf("op%0d %0h,%0h ZHI", vecs[i].op, vecs[i].a, vecs[i].b),
                   SRC_ZHI, SINK_MAR, vecs[i].hi);
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
            if (obs !== e.value) begin
               miscompares++;
               $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
            end
         end
      end
   endtask

   task automatic test_mdr_ba();
      expect_t e;
      logic [31:0] obs;
      dpIf.Mdatain = 32'h0000_ABCD; dpIf.Read = 1; dpIf.MDRin = 1; step();
      sb.push_back('{"MDR from memory", SINK_MDR, 32'h0000_ABCD});
      loadReg(0, 32'd9);
      loadIr(32'h0180_0000);
      dpIf.grb = 1; dpIf.BAout = 1; dpIf.MARin = 1; step();
      sb.push_back('{"BAout R0 gives zero", SINK_MAR, 32'd0});
      dpIf.grb = 1; dpIf.rout = 1; dpIf.PORTin = 1; step();
      sb.push_back('{"grb rout R0", SINK_PORT, 32'd9});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
      loadReg(1, 32'h55);
      loadReg(2, 32'h77);
      dpIf.Mdatain = 32'h0000_DEAD;
      dpIf.RegOut[1] = 1; dpIf.RegOut[2] = 1; dpIf.PCout = 1; dpIf.MDRin = 1; step();
      sb.push_back('{"MDR from bus priority", SINK_MDR, 32'h55});
      dpIf.InPortData = 32'h0000_CAFE; dpIf.PORTout = 1; dpIf.gra = 1; dpIf.rin = 1; step();
      expectVia("gra rin R3", 3, SINK_PORT, 32'h0000_CAFE);
      loadIr(32'h0004_0001);
      dpIf.cout = 1; dpIf.MARin = 1; step();
      sb.push_back('{"C sign extend", SINK_MAR, 32'hFFFC_0001});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
   endtask

   task automatic test_con();
      expect_t e;
      logic [31:0] obs;
      conVec_t vecs [8];
      vecs = '{
         '{32'h0010_0000, 32'd5,         1'b1},
         '{32'h0010_0000, 32'h8000_0000, 1'b0},
         '{32'h0010_0000, 32'd0,         1'b0},
         '{32'h0018_0000, 32'h8000_0000, 1'b1},
         '{32'h0018_0000, 32'd5,         1'b0},
         '{32'h0008_0000, 32'd5,         1'b1},
         '{32'h0008_0000, 32'd0,         1'b0},
         '{32'h0000_0000, 32'd0,         1'b1}
      };
      foreach (vecs[i]) begin
         loadIr(vecs[i].ir);
         dpIf.InPortData = vecs[i].bus; dpIf.PORTout = 1; dpIf.conin = 1; step();
         sb.push_back('{$sformatf("CON ir=%0h bus=%0h", vecs[i].ir, vecs[i].bus),
                        SINK_CON, {31'd0, vecs[i].con}});
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
            if (obs !== e.value) begin
               miscompares++;
               $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      expect_t e;
      logic [31:0] obs;
      loadIr(32'd0);
      loadPc(32'd5);
      dpIf.conin = 1; step();
      dpIf.Mdatain = 32'h1234_5678;
      dpIf.PCout = 1; dpIf.MARin = 1; dpIf.IncPC = 1; dpIf.RZin = 1; step();
      dpIf.RZLOout = 1; dpIf.PCin = 1; dpIf.Read = 1; dpIf.MDRin = 1; step();
      sb.push_back('{"mid MAR before clear", SINK_MAR, 32'd5});
      sb.push_back('{"mid MDR before clear", SINK_MDR, 32'h1234_5678});
      sb.push_back('{"mid CON before clear", SINK_CON, 32'd1});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
      #1 clear = 1'b0;
      #1;
      sb.push_back('{"mid clear MAR", SINK_MAR, 32'd0});
      sb.push_back('{"mid clear MDR", SINK_MDR, 32'd0});
      sb.push_back('{"mid clear CON", SINK_CON, 32'd0});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
      #1 clear = 1'b1;
      expectVia("after clear PC", SRC_PC, SINK_MAR, 32'd0);
      expectVia("after clear IR", SRC_IR, SINK_PORT, 32'd0);
      expectVia("after clear ZLO", SRC_ZLO, SINK_MDR, 32'd0);
      sb.push_back('{"after clear CON", SINK_CON, 32'd0});
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = sinkValue(e.sink); vectorsApplied++;
         if (obs !== e.value) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.tag, obs, e.value);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle();
      dpIf.Mdatain    = '0;
      dpIf.InPortData = '0;
      test_reset();
      test_branch();
      test_add_sub();
      test_alu_ops();
      test_mul_div();
      test_mdr_ba();
      test_con();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
